dv_apb_master: RTL and testbench

APB requester that sits directly upstream of the APB slave models in the DV library and drives their `psel`/`penable`/`paddr`/`pwdata`/`pwrite`/`pstrb` bus. It accepts single transactions on a valid/ready command port and runs the APB SETUP and ACCESS phases. It waits for `pready` with a bounded timeout and returns read data and error status on a valid/ready response port that can hold off the requester. One transaction is in flight at a time.

---
 rtl/dv_apb_master.sv | 154 +++++++++++++++
 tb/tb_dv_apb_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dv_apb_master.sv
// dv_apb_master: single-outstanding APB requester with valid/ready command and
// response ports, a one-hot two-slave select and a bounded pready wait.
module dv_apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [1:0]  psel,
  output logic        penable,
  output logic [19:0] paddr,
  output logic [15:0] pwdata,
  output logic        pwrite,
  output logic [1:0]  pstrb,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // state  | meaning
  // IDLE   | no transfer; accepts a command when no response is held
  // SETUP  | psel high, penable low, exactly one cycle
  // ACCESS | psel and penable high until pready or timeout
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam bit         LP_TMO_EN   = (TIMEOUT != 0);
  localparam logic [4:0] LP_TMO_LAST = LP_TMO_EN ? 5'(TIMEOUT - 1) : 5'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_tcnt;
  logic        r_slv;
  logic [19:0] r_paddr;
  logic [15:0] r_pwdata;
  logic        r_pwrite;
  logic [1:0]  r_pstrb;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rsp_timeout;

  logic        w_cmd_acc;
  logic        w_done;
  logic        w_abort;
  logic        w_tmo_hit;

  assign cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_tmo_hit = LP_TMO_EN && (r_tcnt == LP_TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Counts ACCESS cycles with pready low; saturates so a stuck slave cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= 5'd0;
    end else if (r_state == ST_SETUP) begin
      r_tcnt <= 5'd0;
    end else if ((r_state == ST_ACCESS) && !pready && (r_tcnt != 5'h1F)) begin
      r_tcnt <= r_tcnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slv    <= 1'b0;
      r_paddr  <= 20'h0;
      r_pwdata <= 16'h0;
      r_pwrite <= 1'b0;
      r_pstrb  <= 2'b00;
    end else if (w_cmd_acc) begin
      r_slv    <= cmd_addr[19];
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
      r_pwrite <= cmd_write;
      r_pstrb  <= cmd_write ? cmd_strb : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 16'h0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= r_pwrite ? 16'h0 : prdata;
      r_rsp_err     <= pslverr;
      r_rsp_timeout <= 1'b0;
    end else if (w_abort) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= 16'h0;
      r_rsp_err     <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  // Select and enable decode from state so reset drops them without a clock edge.
  assign psel        = (r_state == ST_IDLE) ? 2'b00 : (r_slv ? 2'b10 : 2'b01);
  assign penable     = (r_state == ST_ACCESS);
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pwrite      = r_pwrite;
  assign pstrb       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_dv_apb_master.sv
// Bench for dv_apb_master: two 32-word memory slaves with programmable wait
// states, a vector table, hand-written corner sequences and a random run.
module tb_dv_apb_master;
  localparam int TMO = 4;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_write;
  logic [1:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  psel;
  logic        penable;
  logic [19:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic [1:0]  pstrb;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  dv_apb_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave model: pready rises after slv_wait ACCESS cycles.
  logic [15:0] tb_mem [2][32];
  logic        mem_clr;
  int          acc_cnt;
  int          slv_wait;
  logic        slv_err;

  assign pready  = (acc_cnt >= slv_wait);
  assign pslverr = slv_err;
  assign prdata  = tb_mem[psel[1]][paddr[4:0]];

  always @(posedge clk) begin
    acc_cnt <= penable ? acc_cnt + 1 : 0;
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) begin
        tb_mem[0][i] <= 16'h0;
        tb_mem[1][i] <= 16'h0;
      end
    end else if (penable && pready && pwrite) begin
      if (pstrb[0]) tb_mem[psel[1]][paddr[4:0]][7:0]  <= pwdata[7:0];
      if (pstrb[1]) tb_mem[psel[1]][paddr[4:0]][15:8] <= pwdata[15:8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: transaction outcome from the wait count alone, plus a word memory.
  logic [15:0] ref_mem [2][32];

  function automatic void ref_txn(input logic [19:0] a, input logic [15:0] d,
                                  input logic w, input logic [1:0] s, input int wt,
                                  input logic er, output int lat, output logic [15:0] rd,
                                  output logic e, output logic t);
    if (TMO != 0 && wt >= TMO) begin
      lat = 2 + TMO; rd = 16'h0; e = 1'b1; t = 1'b0 | 1'b1;
    end else begin
      lat = 3 + wt; e = er; t = 1'b0;
      rd = w ? 16'h0 : ref_mem[a[19]][a[4:0]];
      if (w && s[0]) ref_mem[a[19]][a[4:0]][7:0]  = d[7:0];
      if (w && s[1]) ref_mem[a[19]][a[4:0]][15:8] = d[15:8];
    end
  endfunction

  task automatic run_txn(input logic [19:0] a, input logic [15:0] d, input logic w,
                         input logic [1:0] s, input int wt, input logic er,
                         output int lat, output logic [15:0] rd, output logic e,
                         output logic t, output logic ph_ok);
    int n;
    logic [1:0] exp_sel;
    exp_sel = a[19] ? 2'b10 : 2'b01;
    ph_ok = 1'b1;
    lat = -1;
    slv_wait = wt; slv_err = er;
    cmd_addr = a; cmd_wdata = d; cmd_write = w; cmd_strb = s;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (psel !== exp_sel || penable !== 1'b0) ph_ok = 1'b0;
    for (int k = 2; k < 60; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (psel !== exp_sel || penable !== 1'b1 || paddr !== a || pwrite !== w ||
          pstrb !== (w ? s : 2'b00) || (w && pwdata !== d)) ph_ok = 1'b0;
    end
    rd = rsp_rdata; e = rsp_err; t = rsp_timeout;
    if (psel !== 2'b00 || penable !== 1'b0) ph_ok = 1'b0;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) ph_ok = 1'b0;
  endtask

  typedef struct {
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [1:0]  strb;
    int          wt;
    logic        err;
    int          lat;
    logic [15:0] rd;
    logic        e;
    logic        t;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int          lat, rlat;
    logic [15:0] rd, rrd;
    logic        e, t, ph, re, rt;
    int          n;

    vecs[0]  = '{20'h00004, 16'hBEEF, 1'b1, 2'b11, 0, 1'b0, 3, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{20'h00003, 16'h1234, 1'b1, 2'b11, 0, 1'b0, 3, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{20'h00003, 16'h5555, 1'b0, 2'b11, 0, 1'b0, 3, 16'h1234, 1'b0, 1'b0};
    vecs[3]  = '{20'h80010, 16'h0000, 1'b0, 2'b00, 3, 1'b1, 6, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{20'h00004, 16'h0000, 1'b0, 2'b00, 7, 1'b0, 6, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{20'h80001, 16'hA5C3, 1'b1, 2'b01, 1, 1'b0, 4, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{20'h80001, 16'h0000, 1'b0, 2'b00, 2, 1'b0, 5, 16'h00C3, 1'b0, 1'b0};
    vecs[7]  = '{20'h80001, 16'hFF00, 1'b1, 2'b10, 3, 1'b0, 6, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{20'h80001, 16'h0000, 1'b0, 2'b00, 0, 1'b0, 3, 16'hFFC3, 1'b0, 1'b0};
    vecs[9]  = '{20'h00004, 16'h0000, 1'b1, 2'b11, 4, 1'b0, 6, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{20'h00004, 16'h0000, 1'b0, 2'b00, 0, 1'b0, 3, 16'hBEEF, 1'b0, 1'b0};
    vecs[11] = '{20'h00005, 16'h1111, 1'b1, 2'b11, 0, 1'b1, 3, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 32; i++) begin
      ref_mem[0][i] = 16'h0;
      ref_mem[1][i] = 16'h0;
    end

    reset_n = 1'b0; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_addr = 20'h0; cmd_wdata = 16'h0; cmd_write = 1'b0;
    cmd_strb = 2'b00; rsp_ready = 1'b0; slv_wait = 0; slv_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_psel", 32'(psel), 32'h0);
    chk("reset_penable", 32'(penable), 32'h0);
    chk("reset_paddr", 32'(paddr), 32'h0);
    chk("reset_pwdata", 32'(pwdata), 32'h0);
    chk("reset_pwrite_pstrb", 32'({pwrite, pstrb}), 32'h0);
    chk("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 32'h0);
    mem_clr = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].strb, vecs[i].wt,
              vecs[i].err, lat, rd, e, t, ph);
      ref_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].strb, vecs[i].wt,
              vecs[i].err, rlat, rrd, re, rt);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
      chk($sformatf("vec%0d_timeout", i), 32'(t), 32'(vecs[i].t));
      chk($sformatf("vec%0d_bus_phases", i), 32'(ph), 32'h1);
    end

    // Backpressure: response held for 5 cycles with a second command waiting.
    slv_wait = 0; slv_err = 1'b0;
    cmd_addr = 20'h00004; cmd_write = 1'b0; cmd_strb = 2'b00; cmd_wdata = 16'h0;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_stall%0d_cmd_ready", i), 32'(cmd_ready), 32'h0);
      chk($sformatf("bp_stall%0d_psel", i), 32'({psel, penable}), 32'h0);
      chk($sformatf("bp_stall%0d_rsp", i), 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
          32'({1'b1, 16'hBEEF, 1'b0, 1'b0}));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_valid", 32'(rsp_valid), 32'h0);
    chk("bp_after_hs_cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_next_accept_setup", 32'({psel, penable}), 32'({2'b01, 1'b0}));
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_second_rdata", 32'(rsp_rdata), 32'hBEEF);
    @(posedge clk); #1;

    // Reset asserted while penable is high.
    slv_wait = 20; slv_err = 1'b0;
    cmd_addr = 20'h00008; cmd_wdata = 16'h7777; cmd_write = 1'b1; cmd_strb = 2'b11;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_penable_before", 32'(penable), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_psel", 32'({psel, penable}), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    slv_wait = 0;
    @(posedge clk); #1;
    chk("rst_release_cmd_ready", 32'(cmd_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_response", 32'({rsp_valid, psel, penable}), 32'h0);
    run_txn(20'h00008, 16'h0, 1'b0, 2'b00, 0, 1'b0, lat, rd, e, t, ph);
    chk("rst_write_discarded", 32'(rd), 32'h0);

    // Random transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [19:0] a;
      logic [15:0] d;
      logic        w, er;
      logic [1:0]  s;
      int          wt;
      a  = {1'($urandom_range(0, 1)), 14'($urandom), 5'($urandom_range(0, 3))};
      d  = 16'($urandom);
      w  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      wt = $urandom_range(0, 6);
      er = 1'($urandom_range(0, 1));
      ref_txn(a, d, w, s, wt, er, rlat, rrd, re, rt);
      run_txn(a, d, w, s, wt, er, lat, rd, e, t, ph);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(rlat));
      chk($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(rrd));
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(re));
      chk($sformatf("rnd%0d_timeout", i), 32'(t), 32'(rt));
      chk($sformatf("rnd%0d_bus_phases", i), 32'(ph), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
